ir_receiver: RTL and testbench
==============================

Name: ir_receiver

Overview:
- Bus-mapped IR packet receiver and decoder. It is the receive end of the car-control IR link driven by the IR transmitter peripheral.
- Takes the demodulated IR envelope from the receiver diode module, measures mark and gap widths, and decodes a packet: start mark, car-select mark, then four command bits (Right, Left, Backward, Forward; MSB first).
- Exposes the last command to the microprocessor over the shared 8-bit bus and raises an interrupt when a packet arrives.

Parameters:
- BASE_ADDR, 8'h92, bus base address; occupies BASE_ADDR..BASE_ADDR+2.
- TICK_DIV, 2778, CLK cycles per measurement tick (about 1 carrier period at 36 kHz, 100 MHz).
- MARK_START, 191, nominal start mark in ticks.
- MARK_SELECT, 47, nominal car-select mark in ticks.
- MARK_ONE, 47, nominal asserted-bit mark in ticks.
- MARK_ZERO, 22, nominal deasserted-bit mark in ticks.
- TOL, 6, +/- tolerance in ticks for every mark class.
- GAP_MAX, 60, maximum gap in ticks inside a packet before abort.
- ACTIVE_LOW, 1, 1 = IR_IN low means carrier present.

Ports:
- CLK in 1: system clock.
- RESET in 1: asynchronous, active-high reset.
- IR_IN in 1: demodulated envelope, asynchronous to CLK.
- BUS_ADDR in 8: bus address.
- BUS_DATA inout 8: bus data; tri-stated except during this block's read cycle.
- BUS_WE in 1: bus write enable.
- BUS_INTERRUPT_RAISE out 1: packet-received interrupt.
- BUS_INTERRUPT_ACK in 1: interrupt acknowledge from the processor.

Behaviour:
- Reset (asynchronous):
  - State IDLE; tick prescaler, width counter, shift register, CMD, VALID, PKT_CNT all 0.
  - BUS_INTERRUPT_RAISE = 0; BUS_DATA high-Z.
- Input: 2-flop synchroniser, then polarity fix to internal mark = carrier present. A 1-cycle edge detect feeds the FSM. Latency from IR_IN to the FSM is 3 CLK.
- Tick prescaler:
  - Free-running modulo TICK_DIV; restarted on every mark or gap edge.
  - Width counter counts ticks and saturates at 255.
- FSM states and transitions:
  - IDLE: mark rise → START_MK.
  - START_MK: on fall, width within MARK_START±TOL → GAP1; otherwise → IDLE.
  - GAP1: on rise → SEL_MK; gap > GAP_MAX → ABORT.
  - SEL_MK: on fall, width within MARK_SELECT±TOL → GAP2; otherwise → ABORT.
  - GAP2: on rise → BIT_MK; gap > GAP_MAX → ABORT.
  - BIT_MK: on fall, width within MARK_ONE±TOL shifts in 1, within MARK_ZERO±TOL shifts in 0, else → ABORT.
    - After the 4th bit → DONE.
    - Otherwise → GAP2.
  - DONE (1 cycle): CMD <= shift[3:0]; VALID <= 1; PKT_CNT <= PKT_CNT+1 (wraps 255→0); BUS_INTERRUPT_RAISE <= 1. → IDLE.
  - ABORT (1 cycle): CMD and VALID unchanged. → WAIT_IDLE.
  - WAIT_IDLE: waits for a gap > GAP_MAX, then → IDLE. This prevents resync mid-packet.
- Mark longer than 255 ticks in any state → ABORT (stuck carrier).
- Register map (reads):
  - BASE+0 = {VALID, 3'b000, CMD[3:0]}.
  - BASE+1 = PKT_CNT.
- Register map (writes): write any value to BASE+0 → VALID <= 0.
- Read timing:
  - A read cycle is BUS_ADDR in range with BUS_WE=0.
  - Data and drive-enable are registered: BUS_DATA is driven exactly the cycle after the address is presented. High-Z otherwise.
  - Reading BASE+0 clears VALID on that same registered edge.
- Simultaneous events:
  - DONE in the same cycle as a VALID clear (read or write): VALID = 1, and the new CMD is kept.
  - DONE in the same cycle as BUS_INTERRUPT_ACK: BUS_INTERRUPT_RAISE stays 1.
  - Otherwise ACK clears BUS_INTERRUPT_RAISE on the next edge.
- Addresses outside the block's range: the block never drives BUS_DATA.

Optional Feature:
- Macro: IR_RX_ERRCNT_EN.
- Defined:
  - 8-bit saturating ERR_CNT at BASE+2, incremented on every ABORT entry and holding at 255.
  - Any write to BASE+2 clears it to 0.
  - Reset value is 0.
- Undefined: BASE+2 is not decoded, no ERR_CNT logic exists, and the bus stays high-Z on reads of BASE+2.

Test Plan:
- Sim params TICK_DIV=4, ACTIVE_LOW=1. Send a valid packet with bits 1,0,0,1 → CMD=4'h9. BASE+0 read returns 8'h89 once, then 8'h09. PKT_CNT=1. BUS_INTERRUPT_RAISE=1 until ACK.
- Start mark of 191+TOL+2 ticks → stays/returns to IDLE. No RAISE, CMD unchanged, ERR_CNT unchanged (start rejection is not an abort).
- Valid start and select, then a bit mark of 35 ticks → ABORT. CMD and VALID keep prior values. With IR_RX_ERRCNT_EN, ERR_CNT=1. The next valid packet (after a gap > GAP_MAX) decodes.
- Gap of 61 ticks after the 2nd bit → ABORT. No DONE. 256 forced aborts leave ERR_CNT=255.
- Packet DONE coincident with a BASE+0 read and with ACK → VALID=1, RAISE=1, read data shows the old CMD.
- Assert RESET mid-packet (in BIT_MK) → all outputs reset immediately, BUS_DATA high-Z. A following clean packet decodes normally. 256 packets → PKT_CNT wraps to 0.

Source files
------------

// File: rtl/ir_receiver_if.sv
// Processor-side bus signals of the IR receiver, except the bidirectional
// data lines, which stay a plain inout port on the receiver.
// master: the processor; slave: the IR receiver.
interface ir_receiver_if;
    logic [7:0] BUS_ADDR;
    logic       BUS_WE;
    logic       BUS_INTERRUPT_RAISE;
    logic       BUS_INTERRUPT_ACK;

    modport master (
        output BUS_ADDR,
        output BUS_WE,
        output BUS_INTERRUPT_ACK,
        input  BUS_INTERRUPT_RAISE
    );

    modport slave (
        input  BUS_ADDR,
        input  BUS_WE,
        input  BUS_INTERRUPT_ACK,
        output BUS_INTERRUPT_RAISE
    );
endinterface

// File: rtl/ir_receiver.sv
// IR packet receiver for the car-control link.
// The receiver measures the mark and gap widths of the demodulated envelope in
// prescaled ticks. A packet is a start mark, a car-select mark, and four
// command bits (Right, Left, Backward, Forward), sent MSB first.
// The last command is shown on the 8-bit bus at BASE_ADDR:
//   BASE+0 = {VALID, 3'b000, CMD}, BASE+1 = packet count.
// When a packet is complete, the receiver raises an interrupt.
// The optional macro IR_RX_ERRCNT_EN adds a saturating abort counter at BASE+2.
// A write to BASE+2 clears that counter.
// TICK_DIV must be 1 or more.
module ir_receiver #(
    parameter logic [7:0] BASE_ADDR   = 8'h92,
    parameter int         TICK_DIV    = 2778,
    parameter int         MARK_START  = 191,
    parameter int         MARK_SELECT = 47,
    parameter int         MARK_ONE    = 47,
    parameter int         MARK_ZERO   = 22,
    parameter int         TOL         = 6,
    parameter int         GAP_MAX     = 60,
    parameter bit         ACTIVE_LOW  = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       IR_IN,
    inout  wire  [7:0] BUS_DATA,
    ir_receiver_if.slave bus
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    // The edge cycle counts as the first cycle of the new interval, so an
    // interval of N*TICK_DIV cycles reads back as exactly N ticks.
    localparam logic [TW-1:0] TICK_RST  = (TICK_DIV > 1) ? TW'(1) : TW'(0);
    localparam logic [7:0]    WIDTH_RST = (TICK_DIV == 1) ? 8'd1 : 8'd0;
    localparam logic          IDLE_LVL  = ACTIVE_LOW ? 1'b1 : 1'b0;

    typedef enum logic [3:0] {
        IDLE, START_MK, GAP1, SEL_MK, GAP2, BIT_MK, DONE, ABORT, WAIT_IDLE
    } state_t;

    state_t      state_r, state_next_s;
    logic        ir_meta_r, ir_sync_r, mark_r, mark_d_r;
    logic        rise_s, fall_s, edge_s, tick_s, gap_over_s, sat_s;
    logic [TW-1:0] tick_cnt_r;
    logic [7:0]  width_r;
    logic [3:0]  shift_r, cmd_r;
    logic [1:0]  bit_cnt_r;
    logic        shift_en_s, shift_bit_s;
    logic        valid_r, raise_r, rd_en_r;
    logic [7:0]  pkt_cnt_r, rd_data_r, rd_mux_s;
    logic        addr_cmd_s, addr_cnt_s, hit_s, rd_s, done_s;
`ifdef IR_RX_ERRCNT_EN
    logic        addr_err_s;
    logic [7:0]  err_cnt_r;
`endif

    // The width is within +/-TOL ticks of the nominal mark length.
    function automatic logic in_win(input logic [7:0] w, input int nom);
        return (int'(w) >= nom - TOL) && (int'(w) <= nom + TOL);
    endfunction

    assign rise_s     = mark_r & ~mark_d_r;
    assign fall_s     = ~mark_r & mark_d_r;
    assign edge_s     = rise_s | fall_s;
    assign tick_s     = (tick_cnt_r == TICK_LAST);
    assign gap_over_s = (int'(width_r) > GAP_MAX);
    assign sat_s      = (width_r == 8'd255);
    assign done_s     = (state_r == DONE);

    // Synchronise IR_IN, convert it so that 1 means carrier, and delay it one cycle for edge detection.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ir_meta_r <= IDLE_LVL;
            ir_sync_r <= IDLE_LVL;
            mark_r    <= 1'b0;
            mark_d_r  <= 1'b0;
        end else begin
            ir_meta_r <= IR_IN;
            ir_sync_r <= ir_meta_r;
            mark_r    <= ACTIVE_LOW ? ~ir_sync_r : ir_sync_r;
            mark_d_r  <= mark_r;
        end
    end

    // Tick prescaler and width counter; both restart on every mark or gap edge. The width counter saturates at 255.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tick_cnt_r <= '0;
            width_r    <= 8'd0;
        end else if (edge_s) begin
            tick_cnt_r <= TICK_RST;
            width_r    <= WIDTH_RST;
        end else begin
            tick_cnt_r <= tick_s ? '0 : tick_cnt_r + TW'(1);
            if (tick_s && !sat_s) begin
                width_r <= width_r + 8'd1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Packet decoder: classify each mark when it ends, and time each gap.
    always_comb begin
        state_next_s = state_r;
        shift_en_s   = 1'b0;
        shift_bit_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (rise_s) state_next_s = START_MK;
                else        state_next_s = IDLE;
            end
            START_MK: begin
                if (sat_s)       state_next_s = ABORT;
                else if (fall_s) state_next_s = in_win(width_r, MARK_START) ? GAP1 : IDLE;
                else             state_next_s = START_MK;
            end
            GAP1: begin
                if (gap_over_s)  state_next_s = ABORT;
                else if (rise_s) state_next_s = SEL_MK;
                else             state_next_s = GAP1;
            end
            SEL_MK: begin
                if (sat_s)       state_next_s = ABORT;
                else if (fall_s) state_next_s = in_win(width_r, MARK_SELECT) ? GAP2 : ABORT;
                else             state_next_s = SEL_MK;
            end
            GAP2: begin
                if (gap_over_s)  state_next_s = ABORT;
                else if (rise_s) state_next_s = BIT_MK;
                else             state_next_s = GAP2;
            end
            BIT_MK: begin
                if (sat_s) begin
                    state_next_s = ABORT;
                end else if (fall_s) begin
                    if (in_win(width_r, MARK_ONE) || in_win(width_r, MARK_ZERO)) begin
                        shift_en_s   = 1'b1;
                        shift_bit_s  = in_win(width_r, MARK_ONE);
                        state_next_s = (bit_cnt_r == 2'd3) ? DONE : GAP2;
                    end else begin
                        state_next_s = ABORT;
                    end
                end else begin
                    state_next_s = BIT_MK;
                end
            end
            DONE:  state_next_s = IDLE;
            ABORT: state_next_s = WAIT_IDLE;
            WAIT_IDLE: begin
                // The old mark width is still visible in the cycle of a falling edge, so that cycle is ignored.
                if (!mark_r && !fall_s && gap_over_s) state_next_s = IDLE;
                else                                  state_next_s = WAIT_IDLE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Command bit shift register and bit counter, both cleared between packets.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            shift_r   <= 4'd0;
            bit_cnt_r <= 2'd0;
        end else if (state_r == IDLE) begin
            shift_r   <= 4'd0;
            bit_cnt_r <= 2'd0;
        end else if (shift_en_s) begin
            shift_r   <= {shift_r[2:0], shift_bit_s};
            bit_cnt_r <= bit_cnt_r + 2'd1;
        end
    end

    assign addr_cmd_s = (bus.BUS_ADDR == BASE_ADDR);
    assign addr_cnt_s = (bus.BUS_ADDR == BASE_ADDR + 8'd1);
`ifdef IR_RX_ERRCNT_EN
    assign addr_err_s = (bus.BUS_ADDR == BASE_ADDR + 8'd2);
    assign hit_s      = addr_cmd_s | addr_cnt_s | addr_err_s;
`else
    assign hit_s      = addr_cmd_s | addr_cnt_s;
`endif
    assign rd_s       = hit_s & ~bus.BUS_WE;

    // Read-data multiplexer.
    always_comb begin
        rd_mux_s = 8'h00;
        if (addr_cmd_s)      rd_mux_s = {valid_r, 3'b000, cmd_r};
        else if (addr_cnt_s) rd_mux_s = pkt_cnt_r;
`ifdef IR_RX_ERRCNT_EN
        else if (addr_err_s) rd_mux_s = err_cnt_r;
`endif
        else                 rd_mux_s = 8'h00;
    end

    // Registered bus read, command/status registers, and interrupt.
    // A completed packet takes priority over a VALID clear and over an interrupt acknowledge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_en_r   <= 1'b0;
            rd_data_r <= 8'h00;
            cmd_r     <= 4'd0;
            valid_r   <= 1'b0;
            pkt_cnt_r <= 8'd0;
            raise_r   <= 1'b0;
        end else begin
            rd_en_r   <= rd_s;
            rd_data_r <= rd_s ? rd_mux_s : 8'h00;
            if (done_s) begin
                cmd_r     <= shift_r;
                valid_r   <= 1'b1;
                pkt_cnt_r <= pkt_cnt_r + 8'd1;
            end else if (addr_cmd_s) begin
                valid_r   <= 1'b0;
            end
            if (done_s)                     raise_r <= 1'b1;
            else if (bus.BUS_INTERRUPT_ACK) raise_r <= 1'b0;
        end
    end

`ifdef IR_RX_ERRCNT_EN
    // Saturating abort counter. A write to BASE+2 clears it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            err_cnt_r <= 8'd0;
        end else if (addr_err_s && bus.BUS_WE) begin
            err_cnt_r <= 8'd0;
        end else if (state_r == ABORT && err_cnt_r != 8'd255) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end
    end
`endif

    assign BUS_DATA                = rd_en_r ? rd_data_r : 8'bzzzz_zzzz;
    assign bus.BUS_INTERRUPT_RAISE = raise_r;

endmodule

// File: tb/tb_ir_receiver.sv
// Directed bench for ir_receiver.
// u_dut_a uses the reference timing with TICK_DIV=4.
// u_dut_b uses short mark lengths, so that the long packet-count wrap and
// abort saturation runs stay short.
// The bus data lines are pulled up, so an undriven bus reads 8'hFF.
module tb_ir_receiver;
    localparam int         TD_A = 4;
    localparam int         TD_B = 2;
    localparam logic [7:0] BASE = 8'h92;
    localparam logic [7:0] HIZ  = 8'hFF;

    logic CLK = 1'b0;
    logic rst_a, rst_b, ir_a, ir_b;
    wire [7:0] data_a, data_b;
    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] rd;

    ir_receiver_if bus_a ();
    ir_receiver_if bus_b ();

    for (genvar g = 0; g < 8; g++) begin : g_pull
        pullup pu_a (data_a[g]);
        pullup pu_b (data_b[g]);
    end

    ir_receiver #(.BASE_ADDR(BASE), .TICK_DIV(TD_A)) u_dut_a (
        .CLK(CLK), .RESET(rst_a), .IR_IN(ir_a), .BUS_DATA(data_a), .bus(bus_a.slave)
    );

    ir_receiver #(.BASE_ADDR(BASE), .TICK_DIV(TD_B), .MARK_START(12), .MARK_SELECT(8),
                  .MARK_ONE(8), .MARK_ZERO(4), .TOL(1), .GAP_MAX(6)) u_dut_b (
        .CLK(CLK), .RESET(rst_b), .IR_IN(ir_b), .BUS_DATA(data_b), .bus(bus_b.slave)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Drive one mark (mk=1) or gap of the given number of ticks. The IR input is active low.
    task automatic seg(input bit fast, input bit mk, input int ticks);
        if (fast) ir_b = ~mk;
        else      ir_a = ~mk;
        repeat (ticks * (fast ? TD_B : TD_A)) @(negedge CLK);
    endtask

    task automatic send_pkt(input bit fast, input int st, input int sel, input logic [3:0] bits,
                            input int gap, input int tail);
        int one;
        int zero;
        one  = fast ? 8 : 47;
        zero = fast ? 4 : 22;
        seg(fast, 1'b1, st);
        seg(fast, 1'b0, gap);
        seg(fast, 1'b1, sel);
        seg(fast, 1'b0, gap);
        for (int i = 3; i >= 0; i--) begin
            seg(fast, 1'b1, bits[i] ? one : zero);
            seg(fast, 1'b0, (i == 0) ? tail : gap);
        end
    endtask

    task automatic set_bus(input bit fast, input logic [7:0] a, input logic we, input logic ack);
        if (fast) begin
            bus_b.BUS_ADDR = a; bus_b.BUS_WE = we; bus_b.BUS_INTERRUPT_ACK = ack;
        end else begin
            bus_a.BUS_ADDR = a; bus_a.BUS_WE = we; bus_a.BUS_INTERRUPT_ACK = ack;
        end
    endtask

    task automatic check_rd(input bit fast, input logic [7:0] a, input logic [7:0] exp, input string tag);
        logic [7:0] d;
        @(negedge CLK);
        set_bus(fast, a, 1'b0, 1'b0);
        @(negedge CLK);
        d = fast ? data_b : data_a;
        set_bus(fast, 8'h00, 1'b0, 1'b0);
        chk(tag, d, exp);
    endtask

    task automatic bus_write(input bit fast, input logic [7:0] a);
        @(negedge CLK);
        set_bus(fast, a, 1'b1, 1'b0);
        @(negedge CLK);
        set_bus(fast, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_ack(input bit fast);
        @(negedge CLK);
        set_bus(fast, 8'h00, 1'b0, 1'b1);
        @(negedge CLK);
        set_bus(fast, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; ir_a = 1'b1; ir_b = 1'b1;
        set_bus(1'b0, 8'h00, 1'b0, 1'b0);
        set_bus(1'b1, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge CLK);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge CLK);

        // Reset state and address decode
        chk("rst_raise", {7'd0, bus_a.BUS_INTERRUPT_RAISE}, 8'h00);
        chk("rst_bus_hiz", data_a, HIZ);
        check_rd(1'b0, BASE, 8'h00, "rst_cmd");
        check_rd(1'b0, BASE + 8'd1, 8'h00, "rst_cnt");
`ifdef IR_RX_ERRCNT_EN
        check_rd(1'b0, BASE + 8'd2, 8'h00, "rst_err");
`else
        check_rd(1'b0, BASE + 8'd2, HIZ, "err_unmapped");
`endif
        check_rd(1'b0, 8'h91, HIZ, "below_range");
        check_rd(1'b0, 8'h95, HIZ, "above_range");

        // Packet 1001 -> CMD 9
        send_pkt(1'b0, 191, 47, 4'b1001, 10, 10);
        chk("pkt1_raise", {7'd0, bus_a.BUS_INTERRUPT_RAISE}, 8'h01);
        check_rd(1'b0, BASE, 8'h89, "pkt1_first_read");
        check_rd(1'b0, BASE, 8'h09, "pkt1_second_read");
        check_rd(1'b0, BASE + 8'd1, 8'h01, "pkt1_cnt");
        chk("raise_held", {7'd0, bus_a.BUS_INTERRUPT_RAISE}, 8'h01);
        do_ack(1'b0);
        chk("ack_clear", {7'd0, bus_a.BUS_INTERRUPT_RAISE}, 8'h00);

        // Start mark too long (199 ticks) is rejected without an abort
        seg(1'b0, 1'b1, 199);
        seg(1'b0, 1'b0, 70);
        chk("long_start_raise", {7'd0, bus_a.BUS_INTERRUPT_RAISE}, 8'h00);
        check_rd(1'b0, BASE, 8'h09, "long_start_cmd");
        check_rd(1'b0, BASE + 8'd1, 8'h01, "long_start_cnt");
`ifdef IR_RX_ERRCNT_EN
        check_rd(1'b0, BASE + 8'd2, 8'h00, "long_start_err");
`endif

        // Edge-of-tolerance start (197) and select (41): packet 0110 decodes
        send_pkt(1'b0, 197, 41, 4'b0110, 10, 10);
        do_ack(1'b0);

        // Bit mark of 35 ticks aborts; VALID=1 and CMD 6 are kept
        seg(1'b0, 1'b1, 191); seg(1'b0, 1'b0, 10);
        seg(1'b0, 1'b1, 47);  seg(1'b0, 1'b0, 10);
        seg(1'b0, 1'b1, 35);  seg(1'b0, 1'b0, 70);
        chk("bad_bit_raise", {7'd0, bus_a.BUS_INTERRUPT_RAISE}, 8'h00);
        check_rd(1'b0, BASE, 8'h86, "bad_bit_keep");
        check_rd(1'b0, BASE + 8'd1, 8'h02, "bad_bit_cnt");
`ifdef IR_RX_ERRCNT_EN
        check_rd(1'b0, BASE + 8'd2, 8'h01, "bad_bit_err");
`endif

        // Next packet uses 60-tick gaps (the limit) and decodes: 1100
        send_pkt(1'b0, 191, 47, 4'b1100, 60, 10);
        check_rd(1'b0, BASE, 8'h8C, "gap60_cmd");
        check_rd(1'b0, BASE + 8'd1, 8'h03, "gap60_cnt");
        do_ack(1'b0);

        // 61-tick gap after the second bit aborts
        seg(1'b0, 1'b1, 191); seg(1'b0, 1'b0, 10);
        seg(1'b0, 1'b1, 47);  seg(1'b0, 1'b0, 10);
        seg(1'b0, 1'b1, 47);  seg(1'b0, 1'b0, 10);
        seg(1'b0, 1'b1, 22);  seg(1'b0, 1'b0, 61);
        seg(1'b0, 1'b0, 14);
        chk("gap61_raise", {7'd0, bus_a.BUS_INTERRUPT_RAISE}, 8'h00);
        check_rd(1'b0, BASE, 8'h0C, "gap61_cmd");
        check_rd(1'b0, BASE + 8'd1, 8'h03, "gap61_cnt");
`ifdef IR_RX_ERRCNT_EN
        check_rd(1'b0, BASE + 8'd2, 8'h02, "gap61_err");
`endif

        // Packet 0011 whose DONE cycle coincides with a BASE+0 read and an ACK
        seg(1'b0, 1'b1, 191); seg(1'b0, 1'b0, 10);
        seg(1'b0, 1'b1, 47);  seg(1'b0, 1'b0, 10);
        seg(1'b0, 1'b1, 22);  seg(1'b0, 1'b0, 10);
        seg(1'b0, 1'b1, 22);  seg(1'b0, 1'b0, 10);
        seg(1'b0, 1'b1, 47);  seg(1'b0, 1'b0, 10);
        seg(1'b0, 1'b1, 47);
        ir_a = 1'b1;
        repeat (4) @(negedge CLK);
        set_bus(1'b0, BASE, 1'b0, 1'b1);
        @(negedge CLK);
        rd = data_a;
        set_bus(1'b0, 8'h00, 1'b0, 1'b0);
        chk("coinc_old_data", rd, 8'h0C);
        chk("coinc_raise", {7'd0, bus_a.BUS_INTERRUPT_RAISE}, 8'h01);
        seg(1'b0, 1'b0, 10);
        check_rd(1'b0, BASE, 8'h83, "coinc_valid");
        check_rd(1'b0, BASE + 8'd1, 8'h04, "coinc_cnt");
        do_ack(1'b0);

        // A write to BASE+0 clears VALID
        send_pkt(1'b0, 191, 47, 4'b0101, 10, 10);
        bus_write(1'b0, BASE);
        check_rd(1'b0, BASE, 8'h05, "wr_clear");
        check_rd(1'b0, BASE + 8'd1, 8'h05, "wr_cnt");

        // Reset in the middle of a bit mark, while a read is driving the bus
        seg(1'b0, 1'b1, 191); seg(1'b0, 1'b0, 10);
        seg(1'b0, 1'b1, 47);  seg(1'b0, 1'b0, 10);
        ir_a = 1'b0;
        repeat (20) @(negedge CLK);
        chk("pre_reset_raise", {7'd0, bus_a.BUS_INTERRUPT_RAISE}, 8'h01);
        set_bus(1'b0, BASE + 8'd1, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        chk("pre_reset_drive", data_a, 8'h05);
        rst_a = 1'b1;
        #1;
        chk("reset_hiz", data_a, HIZ);
        chk("reset_raise", {7'd0, bus_a.BUS_INTERRUPT_RAISE}, 8'h00);
        ir_a = 1'b1;
        set_bus(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge CLK);
        rst_a = 1'b0;
        seg(1'b0, 1'b0, 20);
        check_rd(1'b0, BASE, 8'h00, "post_reset_cmd");
        check_rd(1'b0, BASE + 8'd1, 8'h00, "post_reset_cnt");
`ifdef IR_RX_ERRCNT_EN
        check_rd(1'b0, BASE + 8'd2, 8'h00, "post_reset_err");
`endif
        send_pkt(1'b0, 191, 47, 4'b1111, 10, 10);
        check_rd(1'b0, BASE, 8'h8F, "post_reset_pkt");
        check_rd(1'b0, BASE + 8'd1, 8'h01, "post_reset_pkt_cnt");

        // Fast instance: 256 packets wrap PKT_CNT to 0
        for (int i = 0; i < 256; i++) begin
            send_pkt(1'b1, 12, 8, i[3:0], 2, 4);
            if (i == 254) check_rd(1'b1, BASE + 8'd1, 8'hFF, "cnt_255");
        end
        check_rd(1'b1, BASE + 8'd1, 8'h00, "cnt_wrap");
        check_rd(1'b1, BASE, 8'h8F, "wrap_cmd");

`ifdef IR_RX_ERRCNT_EN
        // Fast instance: 256 bad-select aborts saturate ERR_CNT at 255
        for (int i = 0; i < 256; i++) begin
            seg(1'b1, 1'b1, 12); seg(1'b1, 1'b0, 2);
            seg(1'b1, 1'b1, 3);  seg(1'b1, 1'b0, 8);
            if (i == 254) check_rd(1'b1, BASE + 8'd2, 8'hFF, "err_255");
        end
        check_rd(1'b1, BASE + 8'd2, 8'hFF, "err_sat");
        bus_write(1'b1, BASE + 8'd2);
        check_rd(1'b1, BASE + 8'd2, 8'h00, "err_clear");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
